// File: rtl/irq_dispatcher_pkg.sv
// Purpose : shared definitions for the interrupt dispatcher and the core interrupt controller.
// Latency : n/a (types, constants and a helper function only).
// Backpr. : n/a.
// Contents: line count, index/number widths, dispatcher state encoding, index->number helper.
package irq_dispatcher_pkg;

    localparam int unsigned NUM_LINES  = 32;
    localparam int unsigned LINE_IDX_W = 5;
    localparam int unsigned EXT_NUM_W  = 6;

    typedef logic [NUM_LINES-1:0]  line_vec_t;
    typedef logic [LINE_IDX_W-1:0] line_idx_t;
    typedef logic [EXT_NUM_W-1:0]  ext_num_t;

    typedef enum logic [1:0] {
        STT_IDLE = 2'd0,
        STT_REQ  = 2'd1,
        STT_GAP  = 2'd2
    } irq_state_t;

    // External number is the line index zero-extended; the core adds its own vector offset.
    function automatic ext_num_t to_ext_num(input line_idx_t idx);
        return ext_num_t'(idx);
    endfunction

endpackage

// File: rtl/irq_dispatcher_if.sv
// Purpose : device-line, configuration and core-request signals of the interrupt dispatcher.
// Latency : n/a (wiring only).
// Backpr. : request held until a one-cycle iEXT_ACK pulse from the core; config writes never stall.
// Modports: slave = dispatcher, master = device/config/core side.
interface irq_dispatcher_if;
    import irq_dispatcher_pkg::*;

    line_vec_t iDEV_IRQ;
    logic      iCONF_VALID;
    line_idx_t iCONF_ENTRY;
    logic      iCONF_ENABLE;
    logic      iEXT_ACK;
    logic      oEXT_ACTIVE;
    ext_num_t  oEXT_NUM;
    line_vec_t oPENDING;
    logic      oTIMEOUT;

    modport slave (
        input  iDEV_IRQ, iCONF_VALID, iCONF_ENTRY, iCONF_ENABLE, iEXT_ACK,
        output oEXT_ACTIVE, oEXT_NUM, oPENDING, oTIMEOUT
    );

    modport master (
        output iDEV_IRQ, iCONF_VALID, iCONF_ENTRY, iCONF_ENABLE, iEXT_ACK,
        input  oEXT_ACTIVE, oEXT_NUM, oPENDING, oTIMEOUT
    );

endinterface

// File: rtl/irq_rr_select.sv
// Purpose : round-robin pick of one set bit in a 32-bit request vector, searching upward from start.
// Latency : combinational.
// Backpr. : none; vld low when no request bit is set.
// Ports   : req (request vector), start (first index searched), vld (any hit), idx (chosen index).
module irq_rr_select
    import irq_dispatcher_pkg::*;
(
    input  line_vec_t req,
    input  line_idx_t start,
    output logic      vld,
    output line_idx_t idx
);

    line_idx_t cand;

    // Walk offsets from the far end down so the smallest offset from start wins;
    // the 5-bit add provides the 31->0 wrap for free.
    always_comb begin
        vld  = 1'b0;
        idx  = start;
        cand = start;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            cand = start + line_idx_t'(i);
            if (req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/irq_dispatcher.sv
// Purpose : captures rising edges on 32 device lines, queues them as pending bits and issues them one at a time to the core.
// Latency : edge at cycle N -> oEXT_ACTIVE at N+3 on an idle block; one GAP cycle after each ack.
// Backpr. : a request is held (index stable) until iEXT_ACK; further edges accumulate as pending bits.
// Ports   : iCLOCK, iRESET_SYNC (sync, active-high), bus (irq_dispatcher_if.slave: device lines, config writes, core request/ack, status).
module irq_dispatcher
    import irq_dispatcher_pkg::*;
#(
    parameter int unsigned P_ACK_TIMEOUT = 1024
) (
    input  logic              iCLOCK,
    input  logic              iRESET_SYNC,
    irq_dispatcher_if.slave   bus
);

    irq_state_t  state_q, state_nxt;

    line_vec_t   irq_q;          // registered device lines ("current")
    line_vec_t   irq_prev_q;     // edge history ("previous")
    line_vec_t   enable_q, enable_nxt;
    line_vec_t   pending_q, pending_nxt;
    line_vec_t   edge_vec;
    line_vec_t   cfg_clr;
    line_vec_t   ack_clr;

    line_idx_t   cur_idx_q;      // line being requested
    line_idx_t   rr_ptr_q;       // first index of the next search
    logic [15:0] to_cnt_q;
    logic [16:0] to_cnt_inc;
    logic        timeout_q;

    logic        sel_vld;
    line_idx_t   sel_idx;
    logic        req_ack;

    irq_rr_select u_rr_select (
        .req   (pending_q),
        .start (rr_ptr_q),
        .vld   (sel_vld),
        .idx   (sel_idx)
    );

    assign edge_vec   = irq_q & ~irq_prev_q;
    assign req_ack    = (state_q == STT_REQ) && bus.iEXT_ACK;
    assign to_cnt_inc = {1'b0, to_cnt_q} + 17'd1;

    // Pending update. Disabling a line clears its bit; ack clears the granted bit.
    // Edges are masked by both old and new enable, so neither a line being disabled
    // nor one being enabled this cycle can create a pending bit. The set term is
    // applied last so a fresh edge beats the ack clear.
    always_comb begin
        enable_nxt = enable_q;
        cfg_clr    = '0;
        ack_clr    = '0;
        if (bus.iCONF_VALID) begin
            enable_nxt[bus.iCONF_ENTRY] = bus.iCONF_ENABLE;
            if (!bus.iCONF_ENABLE) begin
                cfg_clr[bus.iCONF_ENTRY] = 1'b1;
            end
        end
        if (req_ack) begin
            ack_clr[cur_idx_q] = 1'b1;
        end
        pending_nxt = (pending_q & ~cfg_clr & ~ack_clr) | (edge_vec & enable_q & enable_nxt);
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            STT_IDLE: if (sel_vld)         state_nxt = STT_REQ;
            STT_REQ:  if (bus.iEXT_ACK)    state_nxt = STT_GAP;
            STT_GAP:                       state_nxt = STT_IDLE;
            default:                       state_nxt = STT_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q <= STT_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            irq_q      <= '0;
            irq_prev_q <= '0;
            enable_q   <= '0;
            pending_q  <= '0;
            cur_idx_q  <= '0;
            rr_ptr_q   <= '0;
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            irq_q      <= bus.iDEV_IRQ;
            irq_prev_q <= irq_q;
            enable_q   <= enable_nxt;
            pending_q  <= pending_nxt;

            // Index is latched once on entry and not touched again until the next grant,
            // so a config write on the requested line cannot disturb oEXT_NUM.
            if (state_q == STT_IDLE && sel_vld) begin
                cur_idx_q <= sel_idx;
                to_cnt_q  <= '0;
            end

            if (req_ack) begin
                rr_ptr_q <= cur_idx_q + 5'd1;
            end

            // Only unacknowledged request cycles count towards the timeout.
            if (state_q == STT_REQ && !bus.iEXT_ACK) begin
                if (to_cnt_q != 16'hFFFF) begin
                    to_cnt_q <= to_cnt_inc[15:0];
                end
                if (to_cnt_inc >= 17'(P_ACK_TIMEOUT)) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.oEXT_ACTIVE = (state_q == STT_REQ);
    assign bus.oEXT_NUM    = to_ext_num(cur_idx_q);
    assign bus.oPENDING    = pending_q;
    assign bus.oTIMEOUT    = timeout_q;

endmodule

// File: tb/tb_irq_dispatcher.sv
// Purpose : directed self-checking bench for irq_dispatcher (vector table plus timeout/reset sequences).
// Latency : inputs driven 1 time unit after a rising edge, outputs checked 1 unit after the next edge.
// Backpr. : ack driven by the bench; every wait on the DUT is bounded.
module tb_irq_dispatcher;
    import irq_dispatcher_pkg::*;

    logic iCLOCK = 1'b0;
    logic iRESET_SYNC;

    irq_dispatcher_if bus();

    irq_dispatcher #(.P_ACK_TIMEOUT(8)) dut (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .bus         (bus)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic [31:0] dev;
        logic        cv;
        logic [4:0]  ce;
        logic        cen;
        logic        ack;
        logic        e_act;
        logic [5:0]  e_num;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [31:0] dev, input logic cv, input logic [4:0] ce,
                       input logic cen, input logic ack, input logic e_act, input logic [5:0] e_num,
                       input logic [31:0] e_pend);
        vec_t v;
        v.rst = rst; v.dev = dev; v.cv = cv; v.ce = ce; v.cen = cen; v.ack = ack;
        v.e_act = e_act; v.e_num = e_num; v.e_pend = e_pend;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [31:0] dev, input logic cv, input logic [4:0] ce,
                         input logic cen, input logic ack);
        iRESET_SYNC      = rst;
        bus.iDEV_IRQ     = dev;
        bus.iCONF_VALID  = cv;
        bus.iCONF_ENTRY  = ce;
        bus.iCONF_ENABLE = cen;
        bus.iEXT_ACK     = ack;
    endtask

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_active(input string name);
        int w = 0;
        while (bus.oEXT_ACTIVE !== 1'b1 && w < 10) begin
            step();
            w++;
        end
        check(name, {31'd0, bus.oEXT_ACTIVE}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        //   rst dev           cv ce  en ack  act num pend
        // single line 3: pulse, request, ack, gap
        add(1, 32'h0,        0, 0,  0, 0,   0, 0,  32'h0);
        add(0, 32'h0,        1, 3,  1, 0,   0, 0,  32'h0);
        add(0, 32'h8,        0, 0,  0, 0,   0, 0,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 0,  32'h8);
        add(0, 32'h0,        0, 0,  0, 0,   1, 3,  32'h8);
        add(0, 32'h0,        0, 0,  0, 0,   1, 3,  32'h8);
        add(0, 32'h0,        0, 0,  0, 0,   1, 3,  32'h8);
        add(0, 32'h0,        0, 0,  0, 1,   0, 3,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 3,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 3,  32'h0);
        // round-robin 0,5,31 then wrap back to 0
        add(1, 32'h0,        0, 0,  0, 0,   0, 0,  32'h0);
        add(0, 32'h0,        1, 0,  1, 0,   0, 0,  32'h0);
        add(0, 32'h0,        1, 5,  1, 0,   0, 0,  32'h0);
        add(0, 32'h0,        1, 31, 1, 0,   0, 0,  32'h0);
        add(0, 32'h80000021, 0, 0,  0, 0,   0, 0,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 0,  32'h80000021);
        add(0, 32'h0,        0, 0,  0, 0,   1, 0,  32'h80000021);
        add(0, 32'h0,        0, 0,  0, 1,   0, 0,  32'h80000020);
        add(0, 32'h0,        0, 0,  0, 0,   0, 0,  32'h80000020);
        add(0, 32'h1,        0, 0,  0, 0,   1, 5,  32'h80000020);
        add(0, 32'h0,        0, 0,  0, 1,   0, 5,  32'h80000001);
        add(0, 32'h0,        0, 0,  0, 0,   0, 5,  32'h80000001);
        add(0, 32'h0,        0, 0,  0, 0,   1, 31, 32'h80000001);
        add(0, 32'h0,        0, 0,  0, 1,   0, 31, 32'h00000001);
        add(0, 32'h0,        0, 0,  0, 0,   0, 31, 32'h00000001);
        add(0, 32'h0,        0, 0,  0, 0,   1, 0,  32'h00000001);
        add(0, 32'h0,        0, 0,  0, 1,   0, 0,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 0,  32'h0);
        // disabled line 7, then enabled while held high
        add(0, 32'h80,       0, 0,  0, 0,   0, 0,  32'h0);
        add(0, 32'h80,       0, 0,  0, 0,   0, 0,  32'h0);
        add(0, 32'h80,       1, 7,  1, 0,   0, 0,  32'h0);
        add(0, 32'h80,       0, 0,  0, 0,   0, 0,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 0,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 0,  32'h0);
        // line 2 re-edged in the ack cycle; ack during GAP ignored
        add(0, 32'h0,        1, 2,  1, 0,   0, 0,  32'h0);
        add(0, 32'h4,        0, 0,  0, 0,   0, 0,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 0,  32'h4);
        add(0, 32'h0,        0, 0,  0, 0,   1, 2,  32'h4);
        add(0, 32'h4,        0, 0,  0, 0,   1, 2,  32'h4);
        add(0, 32'h0,        0, 0,  0, 1,   0, 2,  32'h4);
        add(0, 32'h0,        0, 0,  0, 1,   0, 2,  32'h4);
        add(0, 32'h0,        0, 0,  0, 0,   1, 2,  32'h4);
        add(0, 32'h0,        0, 0,  0, 1,   0, 2,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 2,  32'h0);
        // disabling the requested line keeps the request alive
        add(0, 32'h4,        0, 0,  0, 0,   0, 2,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 2,  32'h4);
        add(0, 32'h0,        0, 0,  0, 0,   1, 2,  32'h4);
        add(0, 32'h0,        1, 2,  0, 0,   1, 2,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   1, 2,  32'h0);
        add(0, 32'h0,        0, 0,  0, 1,   0, 2,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 2,  32'h0);
        add(0, 32'h0,        0, 0,  0, 0,   0, 2,  32'h0);

        drive(1, 32'h0, 0, 0, 0, 0);
        step();
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].dev, vecs[i].cv, vecs[i].ce, vecs[i].cen, vecs[i].ack);
            step();
            check($sformatf("row%0d active", i),  {31'd0, bus.oEXT_ACTIVE}, {31'd0, vecs[i].e_act});
            check($sformatf("row%0d num", i),     {26'd0, bus.oEXT_NUM},    {26'd0, vecs[i].e_num});
            check($sformatf("row%0d pending", i), bus.oPENDING,             vecs[i].e_pend);
            check($sformatf("row%0d timeout", i), {31'd0, bus.oTIMEOUT},    32'd0);
        end

        // Timeout: withhold ack on line 9 for 8+ request cycles.
        drive(1, 32'h0, 0, 0, 0, 0);
        step();
        drive(0, 32'h0, 1, 9, 1, 0);
        step();
        drive(0, 32'h200, 0, 0, 0, 0);
        step();
        drive(0, 32'h0, 0, 0, 0, 0);
        step();
        wait_active("to_enter_req");
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("to_cyc%0d timeout", k), {31'd0, bus.oTIMEOUT}, 32'd0);
            check($sformatf("to_cyc%0d num", k),     {26'd0, bus.oEXT_NUM}, 32'd9);
        end
        for (int k = 8; k <= 10; k++) begin
            step();
            check($sformatf("to_cyc%0d timeout", k), {31'd0, bus.oTIMEOUT},    32'd1);
            check($sformatf("to_cyc%0d active", k),  {31'd0, bus.oEXT_ACTIVE}, 32'd1);
            check($sformatf("to_cyc%0d num", k),     {26'd0, bus.oEXT_NUM},    32'd9);
        end
        drive(0, 32'h0, 0, 0, 0, 1);
        step();
        drive(0, 32'h0, 0, 0, 0, 0);
        check("to_late_ack active",  {31'd0, bus.oEXT_ACTIVE}, 32'd0);
        check("to_late_ack pending", bus.oPENDING,             32'd0);
        check("to_late_ack timeout", {31'd0, bus.oTIMEOUT},    32'd1);
        step();
        step();
        check("to_sticky timeout",   {31'd0, bus.oTIMEOUT},    32'd1);

        // Reset during a request, with line 9 held high across reset release.
        drive(0, 32'h200, 0, 0, 0, 0);
        step();
        drive(0, 32'h0, 0, 0, 0, 0);
        step();
        wait_active("rst_enter_req");
        drive(1, 32'h200, 0, 0, 0, 0);
        step();
        check("rst_mid active",  {31'd0, bus.oEXT_ACTIVE}, 32'd0);
        check("rst_mid pending", bus.oPENDING,             32'd0);
        check("rst_mid timeout", {31'd0, bus.oTIMEOUT},    32'd0);
        check("rst_mid num",     {26'd0, bus.oEXT_NUM},    32'd0);
        drive(0, 32'h200, 1, 9, 1, 1);
        step();
        check("stray_ack active",  {31'd0, bus.oEXT_ACTIVE}, 32'd0);
        check("stray_ack pending", bus.oPENDING,             32'd0);
        drive(0, 32'h0, 0, 0, 0, 0);
        step();
        check("release_edge pending", bus.oPENDING, 32'h200);
        step();
        check("release_edge active", {31'd0, bus.oEXT_ACTIVE}, 32'd1);
        check("release_edge num",    {26'd0, bus.oEXT_NUM},    32'd9);
        drive(0, 32'h0, 0, 0, 0, 1);
        step();
        drive(0, 32'h0, 0, 0, 0, 0);
        check("final active",  {31'd0, bus.oEXT_ACTIVE}, 32'd0);
        check("final pending", bus.oPENDING,             32'd0);
        check("final timeout", {31'd0, bus.oTIMEOUT},    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
